rv_lsu: RTL

//  Load/store stage directly after the ALU2 stage. Registers ALU2 results and, for loads/stores,

---
 rtl/rv_lsu.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rv_lsu.sv
// Load/store stage after ALU2: registers ALU2 results, runs one data-bus transaction per load/store, aligns load data.
// Latency: non-memory ops 1 cycle; memory ops 1 cycle plus one cycle per bus wait cycle, writeback in the cycle after ack.
// Backpressure: o_stall is high for every cycle a request is outstanding; build option RV_LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module rv_lsu #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_flush,
    input  logic [31:0] i_add,
    input  logic [31:0] i_result,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wsel,
    input  logic        i_store,
    input  logic        i_load,
    input  logic        i_reg_write,
    input  logic [4:0]  i_rd,
    input  logic [2:0]  i_funct3,
    input  logic        i_to_trap,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wsel,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_stall,
    output logic        o_reg_write,
    output logic [4:0]  o_rd,
    output logic [31:0] o_data,
    output logic        o_to_trap,
    output logic [3:0]  o_trap_cause
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(BUS_TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] add_q, result_q, wdata_q, rdata_q;
    logic [3:0]  wsel_q;
    logic        store_q, load_q, reg_write_q, to_trap_q;
    logic [4:0]  rd_q;
    logic [2:0]  funct3_q;
    logic        bus_we_q;
    logic        bus_err_q;
    logic [7:0]  wd_cnt_q;

    logic        in_bus, in_done, wd_hit;
    logic        mis_in, mis_q;
    logic        bus_trap, mis_trap;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext_data;

    assign in_bus  = (state_q == S_BUS);
    assign in_done = (state_q == S_DONE);
    assign o_stall = in_bus;
    assign wd_hit  = (BUS_TIMEOUT != 0) && ((wd_cnt_q + 8'd1) == TIMEOUT);

`ifdef RV_LSU_MISALIGN_TRAP_EN
    // Halfword needs addr[0]==0, word (and wider encodings) need addr[1:0]==0.
    assign mis_in = ((i_funct3[1:0] == 2'b01) && i_add[0]) ||
                    (i_funct3[1]            && (i_add[1:0] != 2'b00));
    assign mis_q  = ((funct3_q[1:0] == 2'b01) && add_q[0]) ||
                    (funct3_q[1]            && (add_q[1:0] != 2'b00));
`else
    // Misaligned accesses are issued word-aligned; lane select uses only the bits the size needs.
    assign mis_in = 1'b0;
    assign mis_q  = 1'b0;
`endif

    // Stage register: flush kills control bits only, so an outstanding bus access keeps its address/data.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            add_q       <= '0;
            result_q    <= '0;
            wdata_q     <= '0;
            wsel_q      <= '0;
            store_q     <= 1'b0;
            load_q      <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            funct3_q    <= '0;
            to_trap_q   <= 1'b0;
            bus_we_q    <= 1'b0;
        end else if (i_flush) begin
            store_q     <= 1'b0;
            load_q      <= 1'b0;
            reg_write_q <= 1'b0;
            to_trap_q   <= 1'b0;
        end else if (!o_stall) begin
            add_q       <= i_add;
            result_q    <= i_result;
            wdata_q     <= i_wdata;
            wsel_q      <= i_wsel;
            store_q     <= i_store;
            load_q      <= i_load;
            reg_write_q <= i_reg_write;
            rd_q        <= i_rd;
            funct3_q    <= i_funct3;
            to_trap_q   <= i_to_trap;
            bus_we_q    <= i_store;
        end
    end

    // Bus-side state: read data capture, watchdog count and bus-error flag for the DONE cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rdata_q   <= '0;
            wd_cnt_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (in_bus && i_mem_ack) begin
                rdata_q <= i_mem_rdata;
            end
            wd_cnt_q  <= in_bus ? (wd_cnt_q + 8'd1) : 8'd0;
            bus_err_q <= in_bus && !i_mem_ack && wd_hit;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a flush in BUS does not abort the request; ack has priority over the watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                end else if ((i_load || i_store) && !i_to_trap && !mis_in) begin
                    state_d = S_BUS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUS: begin
                if (i_mem_ack || wd_hit) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Load alignment and sign/zero extension from the latched read word.
    always_comb begin
        lane_b   = rdata_q[7:0];
        lane_h   = add_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        ext_data = rdata_q;
        case (add_q[1:0])
            2'd0:    lane_b = rdata_q[7:0];
            2'd1:    lane_b = rdata_q[15:8];
            2'd2:    lane_b = rdata_q[23:16];
            default: lane_b = rdata_q[31:24];
        endcase
        case (funct3_q)
            3'b000:  ext_data = {{24{lane_b[7]}}, lane_b};
            3'b001:  ext_data = {{16{lane_h[15]}}, lane_h};
            3'b100:  ext_data = {24'd0, lane_b};
            3'b101:  ext_data = {16'd0, lane_h};
            default: ext_data = rdata_q;
        endcase
    end

    // Trap sources: a flushed op has load/store cleared, so it cannot raise a bus-error trap.
    assign bus_trap  = in_done && bus_err_q && (load_q || store_q);
    assign mis_trap  = mis_q && (load_q || store_q);
    assign o_to_trap = to_trap_q || bus_trap || mis_trap;

    // Cause for traps raised here; a trap arriving from upstream carries its own cause, so 0 here.
    always_comb begin
        o_trap_cause = 4'd0;
        if (!to_trap_q) begin
            if (bus_trap) begin
                o_trap_cause = load_q ? 4'd5 : 4'd7;
            end else if (mis_trap) begin
                o_trap_cause = load_q ? 4'd4 : 4'd6;
            end
        end
    end

    assign o_reg_write = reg_write_q && !o_to_trap && !in_bus;
    assign o_rd        = rd_q;
    assign o_data      = load_q ? ext_data : result_q;

    assign o_mem_req   = in_bus;
    assign o_mem_we    = in_bus && bus_we_q;
    assign o_mem_addr  = in_bus ? {add_q[31:2], 2'b00} : 32'd0;
    assign o_mem_wdata = in_bus ? wdata_q : 32'd0;
    assign o_mem_wsel  = in_bus ? (bus_we_q ? wsel_q : 4'hF) : 4'h0;

endmodule
